// File: rtl/rmii_soc_detect.sv
// RMII receiver that assembles frame bytes and flags POWERLINK SoC frames.
// Define SOC_DET_FCS_EN to qualify soc_det with a good CRC-32 at frame end.
module rmii_soc_detect #(
  parameter logic [15:0] ETHERTYPE   = 16'h88AB,
  parameter logic [7:0]  SOC_MSGTYPE = 8'h01,
  parameter logic [10:0] MAX_LEN     = 11'd1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rm_crs_dv,
  input  logic [1:0]  rm_rx_data,
  input  logic        fast_eth,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic [10:0] frame_len,
  output logic        soc_det,
`ifdef SOC_DET_FCS_EN
  output logic        fcs_err,
`endif
  output logic        err_align,
  output logic        err_long
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, DATA, DROP, WAIT_IDLE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  div_q, div_d, div_cur;
  logic        crs_q;
  logic        smp;
  logic [5:0]  sh_q, sh_d;
  logic [1:0]  dib_q, dib_d;
  logic [10:0] cnt_q, cnt_d;
  logic        m12_q, m12_d, m13_q, m13_d;
  logic [7:0]  byte_q, byte_d, nbyte;
  logic [10:0] len_q, len_d;
  logic        vld_q, vld_d, sof_q, sof_d;
  logic        eof_q, eof_d, soc_q, soc_d;
  logic        align_q, align_d, long_q, long_d;
`ifdef SOC_DET_FCS_EN
  logic        m14_q, m14_d, fcs_q, fcs_d, crc_ok;
  logic [31:0] crc_q, crc_d, crc_rev;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign crc_rev = {<<{crc_q}};
  assign crc_ok  = (crc_rev == 32'hC704DD7B);
`else
  logic        hit_q, hit_d;
`endif

  // Divider only re-phases on a carrier rise seen from IDLE, so
  // mid-frame CRS_DV toggles cannot disturb the sample point.
  assign div_cur = (state_q == IDLE && rm_crs_dv && !crs_q) ? 4'd0 : div_q;
  assign div_d   = (div_cur == 4'd9) ? 4'd0 : div_cur + 4'd1;
  assign smp     = fast_eth | (div_cur == 4'd5);
  assign nbyte   = {rm_rx_data, sh_q};

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    dib_d   = dib_q;
    cnt_d   = cnt_q;
    m12_d   = m12_q;
    m13_d   = m13_q;
    byte_d  = byte_q;
    len_d   = len_q;
    vld_d   = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    align_d = 1'b0;
    long_d  = 1'b0;
`ifdef SOC_DET_FCS_EN
    m14_d   = m14_q;
    crc_d   = crc_q;
    fcs_d   = 1'b0;
    soc_d   = 1'b0;
`else
    hit_d   = 1'b0;
    soc_d   = hit_q;
`endif
    if (smp) begin
      unique case (state_q)
        WAIT_IDLE: if (!rm_crs_dv) state_d = IDLE;
        IDLE: if (rm_crs_dv && rm_rx_data == 2'b01) state_d = PREAMBLE;
        PREAMBLE: begin
          if (!rm_crs_dv) begin
            state_d = IDLE;
          end else if (rm_rx_data == 2'b11) begin
            state_d = DATA;
            dib_d   = 2'd0;
            cnt_d   = 11'd0;
            m12_d   = 1'b0;
            m13_d   = 1'b0;
`ifdef SOC_DET_FCS_EN
            m14_d   = 1'b0;
            crc_d   = 32'hFFFFFFFF;
`endif
          end else if (rm_rx_data != 2'b01) begin
            state_d = DROP;
          end
        end
        DATA: begin
          if (!rm_crs_dv) begin
            state_d = IDLE;
            eof_d   = 1'b1;
            len_d   = cnt_q;
            align_d = (dib_q != 2'd0);
`ifdef SOC_DET_FCS_EN
            fcs_d   = ~crc_ok;
            soc_d   = crc_ok & m14_q & (dib_q == 2'd0);
`endif
          end else begin
            sh_d  = {rm_rx_data, sh_q[5:2]};
            dib_d = dib_q + 2'd1;
            if (dib_q == 2'd3) begin
              if (cnt_q == MAX_LEN) begin
                state_d = DROP;
                long_d  = 1'b1;
                eof_d   = 1'b1;
                len_d   = MAX_LEN;
              end else begin
                byte_d = nbyte;
                vld_d  = 1'b1;
                sof_d  = (cnt_q == 11'd0);
                cnt_d  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
                if (cnt_q == 11'd12) m12_d = (nbyte == ETHERTYPE[15:8]);
                if (cnt_q == 11'd13) m13_d = (nbyte == ETHERTYPE[7:0]);
`ifdef SOC_DET_FCS_EN
                crc_d = crc_byte(crc_q, nbyte);
                if (cnt_q == 11'd14)
                  m14_d = m12_q & m13_q & (nbyte == SOC_MSGTYPE);
`else
                if (cnt_q == 11'd14)
                  hit_d = m12_q & m13_q & (nbyte == SOC_MSGTYPE);
`endif
              end
            end
          end
        end
        DROP: if (!rm_crs_dv) state_d = IDLE;
        default: state_d = WAIT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_IDLE;
      div_q   <= 4'd0;
      crs_q   <= 1'b0;
      sh_q    <= 6'd0;
      dib_q   <= 2'd0;
      cnt_q   <= 11'd0;
      m12_q   <= 1'b0;
      m13_q   <= 1'b0;
      byte_q  <= 8'd0;
      len_q   <= 11'd0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      soc_q   <= 1'b0;
      align_q <= 1'b0;
      long_q  <= 1'b0;
`ifdef SOC_DET_FCS_EN
      m14_q   <= 1'b0;
      fcs_q   <= 1'b0;
      crc_q   <= 32'hFFFFFFFF;
`else
      hit_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      crs_q   <= rm_crs_dv;
      sh_q    <= sh_d;
      dib_q   <= dib_d;
      cnt_q   <= cnt_d;
      m12_q   <= m12_d;
      m13_q   <= m13_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      vld_q   <= vld_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      soc_q   <= soc_d;
      align_q <= align_d;
      long_q  <= long_d;
`ifdef SOC_DET_FCS_EN
      m14_q   <= m14_d;
      fcs_q   <= fcs_d;
      crc_q   <= crc_d;
`else
      hit_q   <= hit_d;
`endif
    end
  end

  assign rx_byte       = byte_q;
  assign rx_byte_valid = vld_q;
  assign rx_sof        = sof_q;
  assign rx_eof        = eof_q;
  assign frame_len     = eof_q ? len_q : 11'd0;
  assign soc_det       = soc_q;
  assign err_align     = align_q;
  assign err_long      = long_q;
`ifdef SOC_DET_FCS_EN
  assign fcs_err       = fcs_q;
`endif

endmodule

// File: tb/tb_rmii_soc_detect.sv
// Scoreboard bench for rmii_soc_detect: expected bytes, frame ends and
// SoC pulses are queued as frames are driven and consumed by a monitor.
module tb_rmii_soc_detect;

  logic        clk = 1'b0;
  logic        rst;
  logic        rm_crs_dv;
  logic [1:0]  rm_rx_data;
  logic        fast_eth;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic [10:0] frame_len;
  logic        soc_det;
  logic        err_align;
  logic        err_long;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int bidx   = 0;
  int b14_cyc = -100;

  logic [7:0]  fb[$];
  logic [8:0]  exp_b[$];
  logic [12:0] exp_e[$];
  int          exp_s[$];
  logic [8:0]  eb;
  logic [12:0] ee;
  int          es;

  rmii_soc_detect dut (
    .clk           (clk),
    .rst           (rst),
    .rm_crs_dv     (rm_crs_dv),
    .rm_rx_data    (rm_rx_data),
    .fast_eth      (fast_eth),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .rx_sof        (rx_sof),
    .rx_eof        (rx_eof),
    .frame_len     (frame_len),
    .soc_det       (soc_det),
    .err_align     (err_align),
    .err_long      (err_long)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  always @(negedge clk) begin
    if (rx_byte_valid) begin
      check("byte_pending", 32'(exp_b.size() != 0), 1);
      if (exp_b.size() != 0) begin
        eb = exp_b.pop_front();
        check("byte", {rx_sof, rx_byte}, eb);
      end
      bidx = rx_sof ? 0 : bidx + 1;
      if (bidx == 14) b14_cyc = cyc;
    end
    if (rx_sof) check("sof_vld", rx_byte_valid, 1);
    if (err_align || err_long) check("err_eof", rx_eof, 1);
    if (rx_eof) begin
      check("eof_pending", 32'(exp_e.size() != 0), 1);
      if (exp_e.size() != 0) begin
        ee = exp_e.pop_front();
        check("eof", {err_long, err_align, frame_len}, ee);
      end
    end
    if (soc_det) begin
      check("soc_pending", 32'(exp_s.size() != 0), 1);
      if (exp_s.size() != 0) es = exp_s.pop_front();
      check("soc_time", cyc - b14_cyc, 1);
    end
  end

  task automatic mk(input int n, input logic [7:0] t);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    if (n > 12) fb[12] = 8'h88;
    if (n > 13) fb[13] = 8'hAB;
    if (n > 14) fb[14] = t;
  endtask

  task automatic push_expect(input int xd, input int rst_at,
                             input bit bad_pre);
    int nb;
    int lim;
    if (bad_pre) return;
    nb  = fb.size();
    lim = (rst_at >= 0) ? rst_at : ((nb > 1518) ? 1518 : nb);
    for (int i = 0; i < lim; i++) exp_b.push_back({i == 0, fb[i]});
    if (rst_at >= 0) return;
    if (nb > 1518) exp_e.push_back({1'b1, 1'b0, 11'd1518});
    else exp_e.push_back({1'b0, xd != 0, 11'(nb)});
    if (lim >= 15 && fb[12] == 8'h88 && fb[13] == 8'hAB && fb[14] == 8'h01)
      exp_s.push_back(1);
  endtask

  task automatic put_dibit(input logic [1:0] d);
    rm_crs_dv  = 1'b1;
    rm_rx_data = d;
    repeat (fast_eth ? 1 : 10) @(negedge clk);
  endtask

  task automatic send(input int xd, input int rst_at, input bit bad_pre);
    for (int i = 0; i < 31; i++)
      put_dibit((bad_pre && i == 10) ? 2'b00 : 2'b01);
    put_dibit(2'b11);
    for (int i = 0; i < fb.size(); i++) begin
      if (i == rst_at) rst = 1'b1;
      for (int j = 0; j < 4; j++) begin
        put_dibit(fb[i][2*j +: 2]);
        if (i == rst_at && j == 0) begin
          rst = 1'b0;
          check("rst_mid", {rx_byte_valid, rx_eof, soc_det, err_align,
                            err_long, frame_len}, 0);
        end
      end
    end
    for (int j = 0; j < xd; j++) put_dibit(2'b10);
    rm_crs_dv  = 1'b0;
    rm_rx_data = 2'b00;
    repeat (30) @(negedge clk);
  endtask

  task automatic run(input string tag, input int n, input logic [7:0] t,
                     input int xd, input int rst_at, input bit bad_pre);
    mk(n, t);
    push_expect(xd, rst_at, bad_pre);
    send(xd, rst_at, bad_pre);
    check({tag, "_bytes_left"}, exp_b.size(), 0);
    check({tag, "_eof_left"}, exp_e.size(), 0);
    check({tag, "_soc_left"}, exp_s.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    rm_crs_dv  = 1'b0;
    rm_rx_data = 2'b00;
    fast_eth   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset", {rx_byte, rx_byte_valid, rx_sof, rx_eof, frame_len,
                    soc_det, err_align, err_long}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run("soc100", 60, 8'h01, 0, -1, 1'b0);
    run("preq", 60, 8'h03, 0, -1, 1'b0);
    fast_eth = 1'b0;
    repeat (20) @(negedge clk);
    run("soc10", 60, 8'h01, 0, -1, 1'b0);
    fast_eth = 1'b1;
    repeat (20) @(negedge clk);
    run("align", 61, 8'h01, 2, -1, 1'b0);
    run("short14", 14, 8'h01, 0, -1, 1'b0);
    run("min15", 15, 8'h01, 0, -1, 1'b0);
    run("badpre", 60, 8'h01, 0, -1, 1'b1);
    run("long", 1600, 8'h01, 0, -1, 1'b0);
    run("rstmid", 60, 8'h01, 0, 5, 1'b0);
    run("after_rst", 60, 8'h01, 0, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rmii_soc_detect.md
RMII_SOC_DETECT -- requirements
Module: rmii_soc_detect

Interface
REQ-001 The block SHALL have parameter ETHERTYPE, default 16'h88AB, meaning the EtherType that qualifies a POWERLINK frame.
REQ-002 The block SHALL have parameter SOC_MSGTYPE, default 8'h01, meaning the message-type byte (frame byte 14) that identifies an SoC.
REQ-003 The block SHALL have parameter MAX_LEN, default 11'd1518, meaning the maximum accepted frame length in bytes after the SFD.
REQ-004 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  50 MHz RMII reference clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rm_crs_dv  in  1  RMII carrier sense / data valid.
- rm_rx_data  in  2  RMII receive dibit.
- fast_eth  in  1  1 = 100 Mbit (dibit every clk); 0 = 10 Mbit (dibit every 10th clk).
- rx_byte  out  8  assembled frame byte.
- rx_byte_valid  out  1  one-clk strobe qualifying rx_byte.
- rx_sof  out  1  one-clk strobe with the first byte after the SFD.
- rx_eof  out  1  one-clk strobe at frame end.
- frame_len  out  11  byte count of the last frame; valid while rx_eof is high.
- soc_det  out  1  one-clk SoC detect pulse; feeds the SoC retransmit stage.
- err_align  out  1  one-clk strobe: frame ended on an odd dibit.
- err_long  out  1  one-clk strobe: frame exceeded MAX_LEN.

Function
REQ-005 Sample point: with fast_eth=1, every clk SHALL be a sample point.
REQ-006 Sample point: with fast_eth=0, a mod-10 divider SHALL restart at the clk where rm_crs_dv rises, and the sample point SHALL be divider count 5.
REQ-007 The FSM SHALL have the states IDLE, PREAMBLE, DATA, DROP, WAIT_IDLE.
REQ-008 IDLE SHALL go to PREAMBLE on rm_crs_dv=1 with dibit 2'b01.
REQ-009 PREAMBLE SHALL stay in PREAMBLE on 2'b01, go to DATA on 2'b11 (SFD), and go to DROP on any other dibit.
REQ-010 PREAMBLE SHALL go to IDLE when rm_crs_dv=0.
REQ-011 Byte assembly SHALL be LSB first: the first dibit of a byte fills bits [1:0] and the fourth fills bits [7:6].
REQ-012 rx_byte_valid SHALL assert for one clk at the clk after the sample point of the fourth dibit.
REQ-013 rx_sof SHALL coincide with the rx_byte_valid of byte 0.
REQ-014 The byte counter SHALL be 11 bits, SHALL clear at the SFD, SHALL increment per byte, and SHALL saturate at 2047.
REQ-015 DATA SHALL end when rm_crs_dv=0 at a sample point; mid-frame toggles of rm_crs_dv at non-sample clocks SHALL be ignored.
REQ-016 At the end of DATA, rx_eof SHALL pulse one clk later with frame_len equal to the byte count, and the FSM SHALL return to IDLE.
REQ-017 If DATA ends with 1-3 dibits of a byte pending, err_align SHALL pulse together with rx_eof, and the partial byte SHALL be discarded.
REQ-018 When the count would exceed MAX_LEN, the FSM SHALL emit err_long and rx_eof with frame_len=MAX_LEN, then go to DROP.
REQ-019 DROP SHALL produce no output strobes and SHALL return to IDLE on rm_crs_dv=0.
REQ-020 SoC match SHALL require byte12==ETHERTYPE[15:8], byte13==ETHERTYPE[7:0] and byte14==SOC_MSGTYPE.
REQ-021 A frame shorter than 15 bytes SHALL never match.
REQ-022 At most one soc_det pulse SHALL occur per frame.
REQ-023 rx_eof and soc_det in the same clk SHALL both be asserted; neither suppresses the other.

Reset
REQ-024 On rst=1 at a clk edge, all outputs and the divider SHALL be 0 and the FSM SHALL enter WAIT_IDLE.
REQ-025 WAIT_IDLE SHALL go to IDLE only after rm_crs_dv=0 is sampled, so a frame in progress at reset release is ignored.
REQ-026 Reset mid-frame SHALL produce no rx_eof, error or soc_det for that frame.

Configuration
REQ-027 Macro SOC_DET_FCS_EN undefined: soc_det SHALL pulse one clk after rx_byte_valid of byte 14 when the match holds.
REQ-028 Macro SOC_DET_FCS_EN defined: a CRC-32 (poly 04C11DB7, reflected, init FFFFFFFF) SHALL run over all bytes.
REQ-029 With SOC_DET_FCS_EN defined, soc_det SHALL pulse with rx_eof only if the match holds, the residue equals 32'hC704DD7B and no err_align/err_long occurred.
REQ-030 With SOC_DET_FCS_EN defined, output bit fcs_err SHALL be added, pulsing with rx_eof when the residue mismatches.

Verification
REQ-031 100 Mbit: 7x preamble + SFD, 60-byte SoC frame (bytes 12-14 = 88 AB 01) -> rx_sof once, 60 rx_byte_valid, rx_eof with frame_len=60, soc_det once (timing per REQ-027/REQ-029).
REQ-032 Same frame with byte14=8'h03 (PReq) -> no soc_det, rx_eof with frame_len=60.
REQ-033 fast_eth=0, the SoC frame with each dibit held 10 clk -> identical byte sequence, soc_det once.
REQ-034 Frame ended after 61 bytes + 2 dibits -> err_align and rx_eof with frame_len=61.
REQ-035 1600-byte frame -> err_long at byte 1519 with frame_len=1518, no further strobes until rm_crs_dv=0.
REQ-036 rst pulsed at byte 5 of an SoC frame -> no strobes for that frame; the next SoC frame is detected normally.
